// File: rtl/alu_arbiter_if.sv
// Requester / ALU bus bundle for alu_arbiter.
// slave = arbiter side, master = requesters plus ALU side.
interface alu_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [5*N_REQ-1:0]    req_op;
  logic [32*N_REQ-1:0]   req_lhs;
  logic [32*N_REQ-1:0]   req_rhs;
  logic [N_REQ-1:0]      rsp_valid;
  logic [N_REQ-1:0]      rsp_ready;
  logic [32*N_REQ-1:0]   rsp_data;
  logic [4:0]            alu_op;
  logic [31:0]           alu_lhs;
  logic [31:0]           alu_rhs;
  logic [31:0]           alu_res;
  logic [1:0]            grant_id;

  modport slave (
    input  req_valid, req_op, req_lhs, req_rhs, rsp_ready, alu_res,
    output req_ready, rsp_valid, rsp_data, alu_op, alu_lhs, alu_rhs, grant_id
  );

  modport master (
    output req_valid, req_op, req_lhs, req_rhs, rsp_ready, alu_res,
    input  req_ready, rsp_valid, rsp_data, alu_op, alu_lhs, alu_rhs, grant_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between N_REQ requesters.
// One grant per cycle; the result is captured into a per-requester slot
// and handed back over a valid/ready handshake.

// Per-requester response slot: EMPTY/FULL state plus captured result.
module alu_arbiter_slot (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        grant,
  input  logic        rsp_ready,
  input  logic [31:0] alu_res,
  output logic        rsp_valid,
  output logic [31:0] data
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;
  slot_e state, state_nxt;

  // state register
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) state <= EMPTY;
    else        state <= state_nxt;
  end

  // next state: grant fills, response handshake drains (never both at once)
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (grant)     state_nxt = FULL;
      FULL:    if (rsp_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // outputs
  always_comb rsp_valid = (state == FULL);

  // result capture; value is retained after drain until the next grant
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X)     data <= '0;
    else if (grant) data <= alu_res;
  end
endmodule

module alu_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic         CLK,
  input  logic         RST_X,
  alu_arbiter_if.slave bus
);
  logic [N_REQ-1:0]            full;
  logic [N_REQ-1:0]            elig;
  logic [N_REQ-1:0]            gnt;
  logic [2*N_REQ-1:0]          rot;
  logic                        found;
  logic [1:0]                  gid;
  logic [1:0]                  ptr;
  logic [N_REQ-1:0][31:0]      data_q;
  logic [4:0]                  op_mux;
  logic [31:0]                 lhs_mux;
  logic [31:0]                 rhs_mux;

  // A slot still FULL at cycle start blocks its requester (no drain bypass);
  // reset also masks grants so outputs sit at their reset values.
  assign elig = bus.req_valid & ~full & {N_REQ{RST_X}};

  // round-robin pick: rotate eligibility so bit 0 is ptr, take first set bit
  always_comb begin
    rot   = {elig, elig} >> ptr;
    found = 1'b0;
    gid   = '0;
    gnt   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        gid   = (int'(ptr) + k >= N_REQ) ? 2'(int'(ptr) + k - N_REQ)
                                         : 2'(int'(ptr) + k);
      end
    end
    for (int i = 0; i < N_REQ; i++) gnt[i] = found && (gid == 2'(i));
  end

  // priority pointer moves just past the winner; holds when idle
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X)     ptr <= '0;
    else if (found) ptr <= (gid == 2'(N_REQ-1)) ? 2'd0 : gid + 2'd1;
  end

  // ALU operand mux; zeros when nothing is granted
  always_comb begin
    op_mux  = '0;
    lhs_mux = '0;
    rhs_mux = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        op_mux  = bus.req_op[5*i +: 5];
        lhs_mux = bus.req_lhs[32*i +: 32];
        rhs_mux = bus.req_rhs[32*i +: 32];
      end
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    alu_arbiter_slot u_slot (
      .CLK       (CLK),
      .RST_X     (RST_X),
      .grant     (gnt[i]),
      .rsp_ready (bus.rsp_ready[i]),
      .alu_res   (bus.alu_res),
      .rsp_valid (full[i]),
      .data      (data_q[i])
    );
  end

  assign bus.req_ready = gnt;
  assign bus.grant_id  = gid;
  assign bus.alu_op    = op_mux;
  assign bus.alu_lhs   = lhs_mux;
  assign bus.alu_rhs   = rhs_mux;
  assign bus.rsp_valid = full;
  assign bus.rsp_data  = data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (N_REQ=2) with a small reference ALU.
module tb_alu_arbiter;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                         OP_XOR = 5'd4, OP_SLL = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7,
                         OP_SLT = 5'd8, OP_SLTU = 5'd9;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_arbiter_if #(.N_REQ(2)) bus ();
  alu_arbiter #(.N_REQ(2)) dut (.CLK(clk), .RST_X(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference ALU; unknown opcodes give 0
  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $signed(a) >>> b[4:0];
      OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'd0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  always_comb bus.alu_res = alu_f(bus.alu_op, bus.alu_lhs, bus.alu_rhs);

  typedef struct {
    logic        port;
    logic [4:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [4:0] op, input logic [31:0] l,
                       input logic [31:0] r);
    if (p) begin
      bus.req_op[9:5] = op; bus.req_lhs[63:32] = l; bus.req_rhs[63:32] = r;
    end else begin
      bus.req_op[4:0] = op; bus.req_lhs[31:0] = l;  bus.req_rhs[31:0] = r;
    end
  endtask

  function automatic logic [31:0] data_of(input logic p);
    return p ? bus.rsp_data[63:32] : bus.rsp_data[31:0];
  endfunction

  task automatic do_reset();
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_op    = '0;
    bus.req_lhs   = '0;
    bus.req_rhs   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // single-requester transaction: grant, capture next cycle, drain
  task automatic run_vec(input vec_t v);
    logic [1:0] bit_p;
    bit_p = v.port ? 2'b10 : 2'b01;
    @(negedge clk);
    drive(v.port, v.op, v.lhs, v.rhs);
    bus.req_valid = bit_p;
    #1;
    chk("vec_req_ready", 32'(bus.req_ready), 32'(bit_p));
    chk("vec_grant_id",  32'(bus.grant_id),  32'(v.port));
    chk("vec_alu_op",    32'(bus.alu_op),    32'(v.op));
    chk("vec_alu_rhs",   bus.alu_rhs,        v.rhs);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("vec_rsp_valid", 32'(bus.rsp_valid), 32'(bit_p));
    chk("vec_rsp_data",  data_of(v.port),    v.exp);
    bus.rsp_ready = bit_p;
    @(negedge clk);
    bus.rsp_ready = '0;
    #1;
    chk("vec_drained",   32'(bus.rsp_valid), 32'd0);
    chk("vec_retain",    data_of(v.port),    v.exp);
  endtask

  vec_t vecs[9];

  initial begin
    errors = 0;
    checks = 0;
    vecs[0] = '{1'b0, OP_ADD,  32'd5,        32'd7,  32'd12};
    vecs[1] = '{1'b1, OP_SRA,  32'h80000000, 32'd4,  32'hF8000000};
    vecs[2] = '{1'b0, OP_SLT,  32'hFFFFFFFF, 32'd1,  32'd1};
    vecs[3] = '{1'b1, OP_SLTU, 32'hFFFFFFFF, 32'd1,  32'd0};
    vecs[4] = '{1'b0, 5'd31,   32'h55,       32'h3,  32'd0};
    vecs[5] = '{1'b1, OP_SUB,  32'd10,       32'd3,  32'd7};
    vecs[6] = '{1'b0, OP_XOR,  32'h0000F0F0, 32'h0FF0, 32'h0000FF00};
    vecs[7] = '{1'b1, OP_SLL,  32'd1,        32'd31, 32'h80000000};
    vecs[8] = '{1'b0, OP_SRL,  32'h80000000, 32'd4,  32'h08000000};

    // reset values
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_op    = '0;
    bus.req_lhs   = '0;
    bus.req_rhs   = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data0", bus.rsp_data[31:0],  32'd0);
    chk("rst_rsp_data1", bus.rsp_data[63:32], 32'd0);
    chk("rst_alu_op",    32'(bus.alu_op),     32'd0);
    chk("rst_alu_lhs",   bus.alu_lhs,         32'd0);
    chk("rst_grant_id",  32'(bus.grant_id),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table vectors
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // idle drive
    #1;
    chk("idle_alu_op",  32'(bus.alu_op), 32'd0);
    chk("idle_alu_lhs", bus.alu_lhs,     32'd0);
    chk("idle_alu_rhs", bus.alu_rhs,     32'd0);

    // round-robin: both continuously requesting, responses drained at once
    do_reset();
    drive(1'b0, OP_ADD, 32'd1, 32'd2);
    drive(1'b1, OP_ADD, 32'd3, 32'd4);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rr_grant_id",  32'(bus.grant_id),  32'(c % 2));
      chk("rr_req_ready", 32'(bus.req_ready), (c % 2 == 1) ? 32'd2 : 32'd1);
      if (c == 1) chk("rr_data0", bus.rsp_data[31:0],  32'd3);
      if (c == 2) chk("rr_data1", bus.rsp_data[63:32], 32'd7);
      @(negedge clk);
    end

    // backpressure on port0
    do_reset();
    drive(1'b0, OP_ADD, 32'd1, 32'd1);
    bus.req_valid = 2'b01;
    #1 chk("bp_c0_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, OP_ADD, 32'd2, 32'd3);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b10;
    #1 chk("bp_c1_ready", 32'(bus.req_ready), 32'd2);
    @(negedge clk);
    #1 chk("bp_c2_ready", 32'(bus.req_ready), 32'd0);
    chk("bp_c2_valid", 32'(bus.rsp_valid), 32'd3);
    chk("bp_c2_data1", bus.rsp_data[63:32], 32'd5);
    @(negedge clk);
    #1 chk("bp_c3_ready", 32'(bus.req_ready), 32'd2);
    @(negedge clk);
    bus.rsp_ready = 2'b11;
    #1 chk("bp_c4_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.rsp_ready = 2'b10;
    drive(1'b0, OP_ADD, 32'd10, 32'd20);
    #1 chk("bp_c5_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_c5_retain", bus.rsp_data[31:0], 32'd2);
    @(negedge clk);
    bus.req_valid = '0;
    #1 chk("bp_c6_data0", bus.rsp_data[31:0], 32'd30);
    chk("bp_c6_valid0", 32'(bus.rsp_valid[0]), 32'd1);

    // reset mid-operation with port1 FULL and ptr pointing at port1
    do_reset();
    drive(1'b1, OP_ADD, 32'h1230, 32'h4);
    bus.req_valid = 2'b10;
    @(negedge clk);
    drive(1'b0, OP_ADD, 32'd1, 32'd1);
    bus.req_valid = 2'b01;
    #1 chk("mr_grant0", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = '0;
    #1 chk("mr_full_data1", bus.rsp_data[63:32], 32'h1234);
    chk("mr_full_valid", 32'(bus.rsp_valid), 32'd3);
    #1 rst_n = 1'b0;
    #1 chk("mr_async_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mr_async_data1", bus.rsp_data[63:32], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 2'b11;
    drive(1'b1, OP_ADD, 32'd0, 32'd0);
    #1 chk("mr_ptr_reset", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between N requesters: decoder/execute, the address generator and the interpreter helper. It grants at most one ALU operation per cycle by round-robin and captures the ALU result into a per-requester response slot. It also returns results over a valid/ready handshake. It sits between the requesters and the one ALU instance, whose `op`, `lhs` and `rhs` it drives and whose `res` it samples.

## Interface
- `N_REQ`, default 2: number of requesters; legal range 2..4.
- `CLK`  in  1: clock; all state changes on the rising edge.
- `RST_X`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: per-requester operation request.
- `req_ready`  out  N_REQ: per-requester grant; handshake fires when `req_valid[i] & req_ready[i]` at a rising edge.
- `req_op`  in  5*N_REQ: ALU opcode for requester i in bits [5i+4:5i]; uses the ALU opcode encoding.
- `req_lhs`  in  32*N_REQ: left operand for requester i in bits [32i+31:32i].
- `req_rhs`  in  32*N_REQ: right operand for requester i, packed the same way.
- `rsp_valid`  out  N_REQ: response slot i holds an undelivered result.
- `rsp_ready`  in  N_REQ: requester i accepts its response.
- `rsp_data`  out  32*N_REQ: result for requester i.
- `alu_op`  out  5: opcode to the ALU.
- `alu_lhs`  out  32: left operand to the ALU.
- `alu_rhs`  out  32: right operand to the ALU.
- `alu_res`  in  32: ALU result; combinational from `alu_op`, `alu_lhs` and `alu_rhs` within the same cycle.
- `grant_id`  out  2: index of the current grant; valid only while `|req_ready`.

## Operation
- **Per-slot state.** Each requester i has a 1-bit slot state, EMPTY or FULL, plus a 32-bit data register.
  - EMPTY -> FULL on a request handshake for i.
  - FULL -> EMPTY on a response handshake (`rsp_valid[i] & rsp_ready[i]`).
  - `rsp_valid[i]` = FULL.
- **Eligibility.** Requester i is eligible iff `req_valid[i]` is high and slot i is EMPTY at the start of the cycle. A slot draining in the same cycle does not make i eligible; there is no bypass.
- **Arbitration.** This is combinational.
  - Priority pointer `ptr` ranges over 0..N_REQ-1.
  - The winner is the first eligible index scanning `ptr`, `ptr+1`, and so on, modulo N_REQ.
  - At most one bit of `req_ready` is set. It is the winner's bit, or no bit if nothing is eligible.
- **Pointer update.** On each request handshake with winner g, `ptr` <= (g+1) mod N_REQ. With no grant, `ptr` holds.
- **ALU drive.**
  - With a grant: `alu_op`, `alu_lhs` and `alu_rhs` are the winner's fields.
  - With no grant: all three are 0.
- **Capture.** On a handshake, `rsp_data[g]` <= `alu_res`, sampled at the same edge.
- **Data retention.** `rsp_data[i]` is stable while FULL. After drain it keeps its last value until the next capture.
- **Opcodes.** Opcodes are not checked. Unknown opcodes pass through, and the ALU returns 0 for them.
- **Requester obligations.** Once `req_valid[i]` is asserted, the requester holds `req_op`, `req_lhs` and `req_rhs` stable until the grant. Withdrawing `req_valid` before the grant is permitted.
- **Reset.** Asserting `RST_X` low at any time, including mid-transaction, does the following:
  - all slots become EMPTY;
  - all `rsp_data` become 0;
  - `ptr` becomes 0;
  - pending results are discarded.

## Timing
- **Reset values.**
  - `req_ready` = 0 and `rsp_valid` = 0.
  - `rsp_data` = 0.
  - `alu_op`, `alu_lhs` and `alu_rhs` = 0.
  - `grant_id` = 0.
- **Latency.** A request granted in cycle t gives `rsp_valid` high in cycle t+1. This is 1 cycle from grant to response.
- **Throughput.**
  - One ALU operation per cycle in aggregate.
  - Per requester: at most one outstanding operation.
  - With `rsp_ready` tied high, requester i can issue every second cycle. A FULL slot blocks the grant in the drain cycle.
- **Combinational paths.**
  - `req_ready` depends combinationally on `req_valid`, slot state and `ptr`. It does not depend on `rsp_ready`.
  - `alu_*` outputs depend combinationally on `req_*` and the grant.
- **Fairness.** With all requesters continuously eligible, grants rotate 0, 1, ..., N_REQ-1, 0, and so on. Starvation is bounded to N_REQ-1 grants.
- **Simultaneous events.**
  - A response drain on slot i and a grant to requester j≠i may occur in the same cycle.
  - A grant and a drain on the same i cannot coincide.

## Test plan
- **Single ADD.** After reset, port0 requests ADD lhs=5 rhs=7.
  - Expect `req_ready[0]` the same cycle.
  - Expect `rsp_valid[0]=1` and `rsp_data[0]=12` next cycle.
  - Expect the slot to clear after `rsp_ready[0]`.
- **Round-robin order.** Ports 0 and 1 request simultaneously after reset.
  - Port0 is granted in cycle 0 and port1 in cycle 1.
  - With both re-requesting, grants alternate 0, 1, 0, 1.
- **Backpressure.** Hold `rsp_ready[0]=0` with port0 FULL and both ports requesting.
  - Only port1 is granted, and `req_ready[0]` stays 0.
  - After `rsp_ready[0]` pulses, port0 is granted the following cycle.
- **Signed shift and compare.** SRA lhs=0x80000000 rhs=4 gives 0xF8000000. SLT lhs=0xFFFFFFFF rhs=1 gives 1. SLTU with the same operands gives 0.
- **Unknown op and idle drive.**
  - op=31 returns `rsp_data=0`.
  - With no requests, `alu_op`, `alu_lhs` and `alu_rhs` are all 0.
- **Reset mid-operation.** Assert `RST_X` low while port1 is FULL with 0x1234.
  - `rsp_valid` goes 0 and `rsp_data[1]` goes 0 immediately, without waiting for an edge.
  - After release, port0 has priority.
